// File: rtl/branch_predictor_if.sv
// rtl/branch_predictor_if.sv - fetch lookup, EX training and mispredict count bundle
// master = fetch/EX side driving the predictor, slave = the predictor itself.
interface branch_predictor_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] fetch_pc;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            upd_valid;
  logic [XLEN-1:0] upd_pc;
  logic            upd_taken;
  logic [XLEN-1:0] upd_target;
  logic            upd_mispredict;
  logic            flush_all;
  logic [31:0]     mispredict_cnt;

  modport master (
    output fetch_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict, flush_all,
    input  pred_taken, pred_target, mispredict_cnt
  );

  modport slave (
    input  fetch_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict, flush_all,
    output pred_taken, pred_target, mispredict_cnt
  );
endinterface

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit BHT counters for fetch PC select
// Define BP_BYPASS_EN to forward a same-cycle update to a lookup of the same PC.
module branch_predictor #(
  parameter int IDX_BITS = 6,
  parameter int XLEN     = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  branch_predictor_if.slave  bp
);
  localparam int N     = 1 << IDX_BITS;
  localparam int TAG_W = XLEN - IDX_BITS - 2;

  logic [N-1:0]      valid_q;
  logic [1:0]        ctr_q    [N];
  logic [TAG_W-1:0]  tag_q    [N];
  logic [XLEN-1:0]   target_q [N];
  logic [31:0]       miss_cnt_q, miss_cnt_d;

  logic [IDX_BITS-1:0] f_idx, u_idx;
  logic [TAG_W-1:0]    f_tag, u_tag;
  logic                u_hit, u_wr, tgt_we;
  logic [1:0]          ctr_new;
  logic [XLEN-1:0]     tgt_new;

  assign f_idx = bp.fetch_pc[IDX_BITS+1:2];
  assign f_tag = bp.fetch_pc[XLEN-1:IDX_BITS+2];
  assign u_idx = bp.upd_pc[IDX_BITS+1:2];
  assign u_tag = bp.upd_pc[XLEN-1:IDX_BITS+2];

  // Next state of the entry addressed by the update port; a flush drops the write.
  always_comb begin
    u_hit   = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    u_wr    = bp.upd_valid && !bp.flush_all && (u_hit || bp.upd_taken);
    tgt_we  = u_wr && bp.upd_taken;
    tgt_new = bp.upd_taken ? bp.upd_target : target_q[u_idx];
    ctr_new = 2'd2;
    if (u_hit) begin
      if (bp.upd_taken) ctr_new = (ctr_q[u_idx] == 2'd3) ? 2'd3 : ctr_q[u_idx] + 2'd1;
      else              ctr_new = (ctr_q[u_idx] == 2'd0) ? 2'd0 : ctr_q[u_idx] - 2'd1;
    end
  end

  always_comb begin
    miss_cnt_d = miss_cnt_q;
    if (bp.upd_valid && bp.upd_mispredict && (miss_cnt_q != 32'hFFFF_FFFF))
      miss_cnt_d = miss_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= '0;
      miss_cnt_q <= '0;
      for (int i = 0; i < N; i++) ctr_q[i] <= 2'd1;
    end else begin
      miss_cnt_q <= miss_cnt_d;
      if (bp.flush_all) begin
        valid_q <= '0;
      end else if (u_wr) begin
        valid_q[u_idx] <= 1'b1;
        ctr_q[u_idx]   <= ctr_new;
      end
    end
  end

  // Tag/target carry no reset; rst_n still blocks a write so reset discards the update.
  always_ff @(posedge clk) begin
    if (rst_n && u_wr)   tag_q[u_idx]    <= u_tag;
    if (rst_n && tgt_we) target_q[u_idx] <= tgt_new;
  end

  logic              lk_valid, hit;
  logic [TAG_W-1:0]  lk_tag;
  logic [1:0]        lk_ctr;
  logic [XLEN-1:0]   lk_tgt;

  always_comb begin
    lk_valid = valid_q[f_idx];
    lk_tag   = tag_q[f_idx];
    lk_ctr   = ctr_q[f_idx];
    lk_tgt   = target_q[f_idx];
`ifdef BP_BYPASS_EN
    if (rst_n && u_wr && (u_idx == f_idx) && (u_tag == f_tag)) begin
      lk_valid = 1'b1;
      lk_tag   = u_tag;
      lk_ctr   = ctr_new;
      lk_tgt   = tgt_new;
    end
`endif
    hit = lk_valid && (lk_tag == f_tag);
  end

  assign bp.pred_taken     = hit && lk_ctr[1];
  assign bp.pred_target    = hit ? lk_tgt : bp.fetch_pc + XLEN'(4);
  assign bp.mispredict_cnt = miss_cnt_q;
endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed self-checking bench for branch_predictor
module tb_branch_predictor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  branch_predictor_if #(.XLEN(32)) bi ();

  branch_predictor #(.IDX_BITS(6), .XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bp    (bi)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look(input string tag, input logic [31:0] pc,
                      input logic exp_taken, input logic [31:0] exp_tgt);
    bi.fetch_pc = pc;
    #1;
    chk({tag, "_taken"}, {31'd0, bi.pred_taken}, {31'd0, exp_taken});
    chk({tag, "_tgt"}, bi.pred_target, exp_tgt);
  endtask

  task automatic upd(input logic [31:0] pc, input logic taken,
                     input logic [31:0] tgt, input logic mp);
    bi.upd_valid      = 1'b1;
    bi.upd_pc         = pc;
    bi.upd_taken      = taken;
    bi.upd_target     = tgt;
    bi.upd_mispredict = mp;
    tick();
    bi.upd_valid      = 1'b0;
    bi.upd_mispredict = 1'b0;
  endtask

  initial begin
    bi.fetch_pc = 32'h100; bi.upd_valid = 1'b0; bi.upd_pc = '0; bi.upd_taken = 1'b0;
    bi.upd_target = '0; bi.upd_mispredict = 1'b0; bi.flush_all = 1'b0;

    // reset state
    look("rst", 32'h100, 1'b0, 32'h104);
    chk("rst_cnt", bi.mispredict_cnt, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    look("post_rst", 32'h100, 1'b0, 32'h104);

    // allocate then train down
    bi.fetch_pc = 32'h104;
    upd(32'h100, 1'b1, 32'h200, 1'b1);
    look("alloc", 32'h100, 1'b1, 32'h200);
    chk("cnt_1", bi.mispredict_cnt, 32'd1);
    bi.upd_mispredict = 1'b1; tick(); bi.upd_mispredict = 1'b0;
    chk("cnt_no_valid", bi.mispredict_cnt, 32'd1);
    upd(32'h100, 1'b0, 32'h0, 1'b0);
    look("nt1", 32'h100, 1'b0, 32'h200);
    upd(32'h100, 1'b0, 32'h0, 1'b0);
    look("nt2", 32'h100, 1'b0, 32'h200);

    // aliasing on index 0
    look("alias_miss", 32'h200, 1'b0, 32'h204);
    upd(32'h200, 1'b1, 32'h300, 1'b0);
    look("alias_new", 32'h200, 1'b1, 32'h300);
    look("alias_old", 32'h100, 1'b0, 32'h104);

    // not-taken miss never allocates
    upd(32'h80, 1'b0, 32'h999, 1'b0);
    look("nt_noalloc", 32'h80, 1'b0, 32'h84);

    // counter saturation at 0x40
    for (int i = 0; i < 5; i++) upd(32'h40, 1'b1, 32'h80, 1'b0);
    upd(32'h40, 1'b0, 32'h0, 1'b0);
    look("sat_hi", 32'h40, 1'b1, 32'h80);
    upd(32'h40, 1'b0, 32'h0, 1'b0);
    look("sat_dn", 32'h40, 1'b0, 32'h80);

    // same-cycle lookup and update at 0x300
    bi.fetch_pc = 32'h300;
    bi.upd_valid = 1'b1; bi.upd_pc = 32'h300; bi.upd_taken = 1'b1; bi.upd_target = 32'h400;
    #1;
`ifdef BP_BYPASS_EN
    chk("same_taken", {31'd0, bi.pred_taken}, 32'd1);
    chk("same_tgt", bi.pred_target, 32'h400);
`else
    chk("same_taken", {31'd0, bi.pred_taken}, 32'd0);
    chk("same_tgt", bi.pred_target, 32'h304);
`endif
    tick();
    bi.upd_valid = 1'b0;
    look("same_after", 32'h300, 1'b1, 32'h400);

    // flush wins over a simultaneous update; mispredict still counts
    bi.flush_all = 1'b1;
    upd(32'h44, 1'b1, 32'h900, 1'b1);
    bi.flush_all = 1'b0;
    look("flush_upd", 32'h44, 1'b0, 32'h48);
    look("flush_old", 32'h300, 1'b0, 32'h304);
    look("flush_40", 32'h40, 1'b0, 32'h44);
    chk("cnt_flush", bi.mispredict_cnt, 32'd2);

    // mispredict counter saturation
    force dut.miss_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.miss_cnt_q;
    upd(32'h800, 1'b0, 32'h0, 1'b1);
    chk("cnt_max", bi.mispredict_cnt, 32'hFFFF_FFFF);
    upd(32'h800, 1'b0, 32'h0, 1'b1);
    chk("cnt_hold", bi.mispredict_cnt, 32'hFFFF_FFFF);

    // asynchronous reset mid-sequence
    upd(32'h100, 1'b1, 32'h200, 1'b0);
    look("pre_rst", 32'h100, 1'b1, 32'h200);
    rst_n = 1'b0;
    look("in_rst", 32'h100, 1'b0, 32'h104);
    chk("in_rst_cnt", bi.mispredict_cnt, 32'd0);
    upd(32'h104, 1'b1, 32'h500, 1'b1);
    rst_n = 1'b1;
    tick();
    look("rel_100", 32'h100, 1'b0, 32'h104);
    look("rel_104", 32'h104, 1'b0, 32'h108);
    chk("rel_cnt", bi.mispredict_cnt, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Fetch-stage branch predictor for the pipelined RV32 core: a direct-mapped branch target buffer (BTB) plus a 2-bit saturating-counter branch history table (BHT). It sits directly upstream of the PC-select 2:1 mux. Each cycle it looks up the current fetch PC and supplies the mux select (`pred_taken`) and the alternate input (`pred_target`); the EX stage trains it with resolved branch outcomes.

## Interface
- `IDX_BITS`, 6: log2 of the entry count (64 entries); legal range 2..10.
- `XLEN`, 32: PC/target width.
- `clk` in 1: sole clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `fetch_pc` in XLEN: PC presented by the IF stage.
- `pred_taken` out 1: select for the PC mux (1 = take `pred_target`).
- `pred_target` out XLEN: predicted next PC.
- `upd_valid` in 1: EX reports a resolved control-transfer instruction this cycle.
- `upd_pc` in XLEN: PC of the resolved instruction.
- `upd_taken` in 1: actual direction.
- `upd_target` in XLEN: actual taken target.
- `upd_mispredict` in 1: EX detected a direction or target mispredict (qualified by `upd_valid`).
- `flush_all` in 1: synchronous invalidate of all BTB entries.
- `mispredict_cnt` out 32: saturating count of mispredicts.

## Operation
- Index = `pc[IDX_BITS+1:2]`; tag = `pc[XLEN-1:IDX_BITS+2]`; `pc[1:0]` is ignored.
- Per entry: `valid` (1), `tag`, `target` (XLEN), `ctr` (2 bits).
- Lookup is combinational: hit = `valid[idx] && tag[idx]==fetch_tag`.
  - `pred_taken` = hit && `ctr[idx][1]`.
  - `pred_target` = `target[idx]` on hit, otherwise `fetch_pc + 4` (mod 2^XLEN).
- Update when `upd_valid`=1:
  - **Tag match**: the counter saturates up if `upd_taken`, down otherwise (3 stays 3, 0 stays 0). `target` is rewritten only when `upd_taken`=1.
  - **Tag miss with `upd_taken`=1**: allocate. Set valid=1 and write tag and target. `ctr`=2 (weakly taken).
  - **Tag miss with `upd_taken`=0**: no change. Not-taken branches are never allocated.
- `mispredict_cnt` increments when `upd_valid && upd_mispredict`. It saturates at 0xFFFFFFFF.
- If `flush_all` and `upd_valid` occur in the same cycle, flush wins: all valid bits clear and the update is dropped. `mispredict_cnt` still counts.
- Reset (`rst_n`=0, asynchronous):
  - All valid bits = 0; all `ctr` = 1 (weakly not-taken); `mispredict_cnt` = 0.
  - Tag and target arrays are not reset.
  - Outputs during reset: `pred_taken`=0, `pred_target`=`fetch_pc+4`.
  - Reset asserted mid-update discards that update.

## Timing
- Lookup latency 0 cycles: the outputs are a function of `fetch_pc` and the state registered at the last edge.
- An update is visible to a lookup starting in the cycle after the edge on which it was applied.
- Same-cycle lookup and update to the same index: the lookup sees the old entry, unless `BP_BYPASS_EN` is defined.
- One update per cycle. The update path is never stalled; there is no ready signal.
- Reset release: the first edge with `rst_n`=1 may apply an update.

## Configuration
- `BP_BYPASS_EN` defined: when `upd_valid` and `upd_pc` share index and tag with `fetch_pc` in the same cycle, the lookup uses the post-update entry (new counter, target and valid). The bypass is suppressed when `flush_all`=1.
- `BP_BYPASS_EN` undefined: no bypass; the lookup always sees the registered state.

## Test plan
- Reset, then `fetch_pc`=0x100 -> `pred_taken`=0, `pred_target`=0x104; `mispredict_cnt`=0.
- Update pc=0x100, taken, target 0x200 -> next cycle `fetch_pc`=0x100 gives `pred_taken`=1, `pred_target`=0x200. Two not-taken updates then give `pred_taken`=0.
- Aliasing: allocate 0x100 (IDX_BITS=6), then look up 0x200 (same index, different tag) -> miss, `pred_target`=0x204. Taken update at 0x200 replaces the entry -> 0x100 now misses.
- Saturation: five taken updates then one not-taken at 0x40 -> `ctr`=2, still predicts taken. Also force 0xFFFFFFFF mispredicts -> counter holds.
- Same-cycle lookup and taken update at 0x300 (fresh entry) -> `pred_taken`=0 without the macro, 1 with `BP_BYPASS_EN`. `flush_all` together with an update -> entry absent next cycle.
- Assert `rst_n` low mid-sequence after allocating 0x100 -> outputs drop immediately to the not-taken default. After release, 0x100 misses.
